// File: rtl/booth_pkg.sv
// Shared Booth select encodings and the sequencer state type used by the encoder.
package booth_pkg;

  localparam int unsigned SEL_W = 4;

  // out_sel bit order is {X1, X2, NEG1, NEG2}
  localparam logic [SEL_W-1:0] SEL_ZERO = 4'b0000;
  localparam logic [SEL_W-1:0] SEL_P1   = 4'b1000;
  localparam logic [SEL_W-1:0] SEL_P2   = 4'b0100;
  localparam logic [SEL_W-1:0] SEL_N1   = 4'b0010;
  localparam logic [SEL_W-1:0] SEL_N2   = 4'b0001;

  typedef enum logic {
    IDLE,
    EMIT
  } state_e;

endpackage

// File: rtl/booth_digit_enc.sv
// Radix-4 Booth triplet {y[2i+1], y[2i], y[2i-1]} to one-hot-or-zero partial-product select.
module booth_digit_enc
  import booth_pkg::*;
(
  input  logic [2:0]       i_trip,
  output logic [SEL_W-1:0] o_sel
);

  always_comb begin
    o_sel = SEL_ZERO;
    unique case (i_trip)
      3'b001, 3'b010: o_sel = SEL_P1;
      3'b011:         o_sel = SEL_P2;
      3'b100:         o_sel = SEL_N2;
      3'b101, 3'b110: o_sel = SEL_N1;
      default:        o_sel = SEL_ZERO;
    endcase
  end

endmodule

// File: rtl/booth_seq_encoder.sv
// Sequential radix-4 Booth encoder: captures one multiplier, emits one select beat per group.
// Optional zero-digit skipping is enabled by defining BOOTH_SKIP_ZERO_EN.
module booth_seq_encoder
  import booth_pkg::*;
#(
  parameter int unsigned  MUL_W = 16,
  localparam int unsigned NG    = MUL_W / 2,
  localparam int unsigned IDX_W = $clog2(NG)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [MUL_W-1:0] in_mul,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SEL_W-1:0] out_sel,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last
);

  state_e           r_state, w_state_nxt;
  logic [MUL_W-1:0] r_mul, w_mul_nxt;
  logic [IDX_W-1:0] r_idx, w_idx_nxt;

  logic [MUL_W:0]   w_ext;
  logic [2:0]       w_trip_r [NG];
  logic [SEL_W-1:0] w_sel;
  logic [IDX_W-1:0] w_start_idx;
  logic [IDX_W-1:0] w_step_idx;
  logic             w_last;

  // Appending y[-1] = 0 lets every group be a plain 3-bit slice
  assign w_ext = {r_mul, 1'b0};

  for (genvar g = 0; g < NG; g++) begin : g_trip
    assign w_trip_r[g] = w_ext[2*g +: 3];
  end

  booth_digit_enc u_digit_enc (
    .i_trip (w_trip_r[r_idx]),
    .o_sel  (w_sel)
  );

`ifdef BOOTH_SKIP_ZERO_EN
  logic [MUL_W:0] w_ext_in;
  logic [NG-1:0]  w_nz_in;
  logic [NG-1:0]  w_nz_r;

  assign w_ext_in = {in_mul, 1'b0};

  // A digit is zero exactly when its triplet is all-zeros or all-ones
  for (genvar g = 0; g < NG; g++) begin : g_nz
    assign w_nz_in[g] = (w_ext_in[2*g +: 3] != 3'b000) && (w_ext_in[2*g +: 3] != 3'b111);
    assign w_nz_r[g]  = (w_trip_r[g] != 3'b000) && (w_trip_r[g] != 3'b111);
  end

  // Start at the lowest nonzero group; an all-zero operand still gets one beat at idx 0
  always_comb begin
    w_start_idx = '0;
    for (int j = NG - 1; j >= 0; j--) begin
      if (w_nz_in[j]) w_start_idx = IDX_W'(j);
    end
  end

  always_comb begin
    w_step_idx = r_idx;
    w_last     = 1'b1;
    for (int j = NG - 1; j >= 0; j--) begin
      if (w_nz_r[j] && (j > int'(r_idx))) begin
        w_step_idx = IDX_W'(j);
        w_last     = 1'b0;
      end
    end
  end
`else
  assign w_start_idx = '0;
  assign w_step_idx  = r_idx + 1'b1;
  assign w_last      = (r_idx == IDX_W'(NG - 1));
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_mul_nxt   = r_mul;
    w_idx_nxt   = r_idx;
    case (r_state)
      IDLE: begin
        if (in_valid) begin
          w_state_nxt = EMIT;
          w_mul_nxt   = in_mul;
          w_idx_nxt   = w_start_idx;
        end
      end
      EMIT: begin
        if (out_ready) begin
          if (w_last) begin
            w_state_nxt = IDLE;
            w_idx_nxt   = '0;
          end else begin
            w_idx_nxt   = w_step_idx;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_mul   <= '0;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_mul   <= w_mul_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  // Outputs decode straight from state so reset clears them without a clock edge
  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == EMIT);
  assign out_sel   = out_valid ? w_sel : SEL_ZERO;
  assign out_idx   = r_idx;
  assign out_last  = out_valid & w_last;

endmodule

// File: tb/tb_booth_seq_encoder.sv
// Self-checking bench for booth_seq_encoder (MUL_W=16): vector table, scoreboard, corner sequences.
module tb_booth_seq_encoder;

`ifdef BOOTH_SKIP_ZERO_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  typedef struct packed {
    logic [2:0] idx;
    logic [3:0] sel;
    logic       last;
  } beat_t;

  // sels: expected select per group, group i in nibble i (no skipping applied)
  typedef struct {
    logic [15:0] mul;
    logic [31:0] sels;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_mul;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_sel;
  logic [2:0]  out_idx;
  logic        out_last;

  beat_t  exp_q[$];
  int     val_q[$];
  int     cnt_q[$];
  int     n_cmp = 0;
  int     n_err = 0;
  longint acc   = 0;
  int     nbeats = 0;

  booth_seq_encoder #(
    .MUL_W (16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mul    (in_mul),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sel   (out_sel),
    .out_idx   (out_idx),
    .out_last  (out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int digit_of(input logic [3:0] s);
    case (s)
      4'b1000: return 1;
      4'b0100: return 2;
      4'b0010: return -1;
      4'b0001: return -2;
      default: return 0;
    endcase
  endfunction

  // Arithmetic Booth model: d = -2*y[2i+1] + y[2i] + y[2i-1]
  function automatic logic [31:0] model_sels(input logic [15:0] m);
    logic [16:0] e;
    logic [31:0] r;
    int          d;
    e = {m, 1'b0};
    r = '0;
    for (int i = 0; i < 8; i++) begin
      d = -2 * int'(e[2*i+2]) + int'(e[2*i+1]) + int'(e[2*i]);
      case (d)
        1:       r[4*i +: 4] = 4'b1000;
        2:       r[4*i +: 4] = 4'b0100;
        -1:      r[4*i +: 4] = 4'b0010;
        -2:      r[4*i +: 4] = 4'b0001;
        default: r[4*i +: 4] = 4'b0000;
      endcase
    end
    return r;
  endfunction

  task automatic push_expected(input logic [15:0] m, input logic [31:0] sels);
    beat_t       b[8];
    int          n;
    logic [3:0]  s;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      s = sels[4*i +: 4];
      if (!SKIP || s != 4'h0) begin
        b[n].idx  = 3'(i);
        b[n].sel  = s;
        b[n].last = 1'b0;
        n++;
      end
    end
    if (n == 0) begin
      b[0].idx  = 3'd0;
      b[0].sel  = 4'h0;
      b[0].last = 1'b0;
      n = 1;
    end
    b[n-1].last = 1'b1;
    for (int i = 0; i < n; i++) exp_q.push_back(b[i]);
    val_q.push_back(int'($signed(m)));
    cnt_q.push_back(n);
  endtask

  task automatic send(input logic [15:0] m, input logic [31:0] sels);
    int g;
    g = 0;
    while (!in_ready && g < 100) begin
      @(posedge clk);
      #1;
      g++;
    end
    check("in_ready_wait", 32'(in_ready), 32'd1);
    push_expected(m, sels);
    in_valid = 1'b1;
    in_mul   = m;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_mul   = 16'h0;
    check("latency_valid", 32'(out_valid), 32'd1);
    check("busy_not_ready", 32'(in_ready), 32'd0);
  endtask

  task automatic wait_idle(input bit rnd_bp);
    int g;
    g = 0;
    while ((exp_q.size() != 0 || !in_ready) && g < 400) begin
      if (rnd_bp) out_ready = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      g++;
    end
    out_ready = 1'b1;
    check("drain_queue", 32'(exp_q.size()), 32'd0);
  endtask

  // Scoreboard: sample on the falling edge, between input updates and accepting edges
  always @(negedge clk) begin
    beat_t e;
    int    v;
    int    c;
    if (!rst_n) begin
      acc    = 0;
      nbeats = 0;
    end else if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_beat", {24'h0, 1'b0, out_idx, out_sel}, 32'hffff_ffff);
      end else begin
        e = exp_q.pop_front();
        check("beat_idx", 32'(out_idx), 32'(e.idx));
        check("beat_sel", 32'(out_sel), 32'(e.sel));
        check("beat_last", 32'(out_last), 32'(e.last));
      end
      acc += longint'(digit_of(out_sel)) * (longint'(1) << (2 * int'(out_idx)));
      nbeats++;
      if (out_last) begin
        v = (val_q.size() != 0) ? val_q.pop_front() : 0;
        c = (cnt_q.size() != 0) ? cnt_q.pop_front() : 0;
        check("recon_value", 32'(acc), 32'(v));
        check("beat_count", 32'(nbeats), 32'(c));
        acc    = 0;
        nbeats = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        tbl[9];
    logic [31:0] bp_sels;
    logic [15:0] bp_mul;
    logic [15:0] rm;
    int          g;

    tbl[0] = '{mul: 16'h0003, sels: 32'h0000_0082};
    tbl[1] = '{mul: 16'h8000, sels: 32'h1000_0000};
    tbl[2] = '{mul: 16'hFFFF, sels: 32'h0000_0002};
    tbl[3] = '{mul: 16'h0001, sels: 32'h0000_0008};
    tbl[4] = '{mul: 16'h0000, sels: 32'h0000_0000};
    tbl[5] = '{mul: 16'h7FFF, sels: 32'h4000_0002};
    tbl[6] = '{mul: 16'h1234, sels: 32'h0881_8280};
    tbl[7] = '{mul: 16'hAAAA, sels: 32'h2222_2221};
    tbl[8] = '{mul: 16'h5555, sels: 32'h8888_8888};

    rst_n     = 1'b1;
    in_valid  = 1'b0;
    in_mul    = 16'h0;
    out_ready = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_sel", 32'(out_sel), 32'd0);
    check("rst_out_idx", 32'(out_idx), 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Vector table, issued back to back
    for (int i = 0; i < 9; i++) send(tbl[i].mul, tbl[i].sels);
    wait_idle(1'b0);

    // Ready returns one cycle after the last beat
    send(16'h0003, 32'h0000_0082);
    g = 0;
    while (!(out_valid && out_last) && g < 20) begin
      @(posedge clk);
      #1;
      g++;
    end
    check("last_seen", 32'(out_last), 32'd1);
    @(posedge clk);
    #1;
    check("ready_after_last", 32'(in_ready), 32'd1);
    check("valid_after_last", 32'(out_valid), 32'd0);

    // Backpressure at idx2 held for three cycles
    bp_mul  = SKIP ? 16'h5555 : 16'hFFFF;
    bp_sels = SKIP ? 32'h8888_8888 : 32'h0000_0002;
    send(bp_mul, bp_sels);
    g = 0;
    while (out_idx != 3'd2 && g < 20) begin
      @(posedge clk);
      #1;
      g++;
    end
    check("bp_reach_idx2", 32'(out_idx), 32'd2);
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      check("bp_hold_valid", 32'(out_valid), 32'd1);
      check("bp_hold_idx", 32'(out_idx), 32'd2);
      check("bp_hold_sel", 32'(out_sel), 32'(bp_sels[11:8]));
      check("bp_hold_last", 32'(out_last), 32'd0);
    end
    out_ready = 1'b1;
    wait_idle(1'b0);

    // in_valid during EMIT is ignored
    send(16'hAAAA, 32'h2222_2221);
    in_valid = 1'b1;
    in_mul   = 16'h1234;
    repeat (2) begin
      @(posedge clk);
      #1;
      check("pulse_busy", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    in_mul   = 16'h0;
    wait_idle(1'b0);

    // Asynchronous reset in the middle of an operand
    send(16'h5555, 32'h8888_8888);
    g = 0;
    while (out_idx != 3'd4 && g < 20) begin
      @(posedge clk);
      #1;
      g++;
    end
    check("rst_reach_idx4", 32'(out_idx), 32'd4);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_idx", 32'(out_idx), 32'd0);
    check("mid_rst_sel", 32'(out_sel), 32'd0);
    check("mid_rst_ready", 32'(in_ready), 32'd1);
    exp_q.delete();
    val_q.delete();
    cnt_q.delete();
    @(posedge clk);
    #2 rst_n = 1'b1;
    #1;
    check("post_rst_ready", 32'(in_ready), 32'd1);
    check("post_rst_valid", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    send(16'h0001, 32'h0000_0008);
    wait_idle(1'b0);

    // Random operands against the arithmetic model with random backpressure
    for (int i = 0; i < 16; i++) begin
      rm = 16'($urandom());
      send(rm, model_sels(rm));
      wait_idle(1'b1);
    end

    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
